pspin_her_sched: RTL
====================

# pspin_her_sched

Per-context HER scheduler between the per-context HER sources and the PsPIN wrapper HER port. It arbitrates round-robin among `NUM_HANDLER_CTX` HER request streams. It enforces a per-context limit on in-flight HERs and counts outstanding HERs per context. It releases a context's credits when PsPIN feedback arrives for that context. Output is a single registered HER stream tagged with the winning context index.

## Interface
Parameters:
- `NUM_HANDLER_CTX`, 4, number of requesting execution contexts (≥2)
- `AXI_ADDR_WIDTH`, 32, HER address/size width
- `MSG_ID_WIDTH`, 10, message ID width
- `CREDIT_WIDTH`, 8, width of in-flight counters and limits
- `DEFAULT_CREDITS`, 16, per-context limit loaded at reset
- `CTX_WIDTH`, `$clog2(NUM_HANDLER_CTX)`, context index width (derived)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `conf_credit_limit`  in  `NUM_HANDLER_CTX*CREDIT_WIDTH`  per-context in-flight limit
- `conf_valid`  in  1  latch `conf_credit_limit` this cycle
- `s_her_valid`  in  `NUM_HANDLER_CTX`  per-context request valid
- `s_her_ready`  out  `NUM_HANDLER_CTX`  per-context accept, one-hot or zero
- `s_her_addr`  in  `NUM_HANDLER_CTX*AXI_ADDR_WIDTH`  HER address
- `s_her_size`  in  `NUM_HANDLER_CTX*AXI_ADDR_WIDTH`  HER size
- `s_her_msgid`  in  `NUM_HANDLER_CTX*MSG_ID_WIDTH`  message ID
- `s_her_is_eom`  in  `NUM_HANDLER_CTX`  end-of-message flag
- `m_her_valid`  out  1  HER to PsPIN wrapper valid
- `m_her_ready`  in  1  wrapper accept
- `m_her_addr` / `m_her_size`  out  `AXI_ADDR_WIDTH`  registered HER fields
- `m_her_msgid`  out  `MSG_ID_WIDTH`  registered message ID
- `m_her_is_eom`  out  1  registered EOM flag
- `m_her_ctx`  out  `CTX_WIDTH`  granted context index
- `feedback_valid`  in  1  PsPIN completed one HER
- `feedback_ready`  out  1  constant 1 outside reset
- `feedback_ctx`  in  `CTX_WIDTH`  context of the completed HER
- `stat_inflight`  out  `NUM_HANDLER_CTX*CREDIT_WIDTH`  current in-flight counts
- `stat_underflow`  out  1  sticky: feedback arrived for a context with zero in flight

## Operation
- Context i is eligible when `s_her_valid[i]` is high and `inflight[i] < limit[i]` (unsigned compare).
- Load condition is `load = !m_her_valid || m_her_ready`.
- When `load` is high and at least one context is eligible, grant the first eligible index scanning from `rr_ptr` upward with modulo wrap.
- On a grant:
  - `s_her_ready[grant]` is driven combinationally high in the same cycle.
  - The granted request's fields and `grant` are loaded into the output register, and `m_her_valid` is set.
  - `rr_ptr` becomes `(grant+1) mod NUM_HANDLER_CTX`.
  - `inflight[grant]` increments.
- When `load` is high and no context is eligible, `m_her_valid` clears.
- Feedback: on `feedback_valid`, `inflight[feedback_ctx]` decrements if it is nonzero. If it is zero, the counter is unchanged and `stat_underflow` is set until reset.
- A grant and a feedback to the same context in the same cycle leave the counter unchanged.
- A `feedback_ctx` value ≥ `NUM_HANDLER_CTX` is ignored and also sets `stat_underflow`.
- `conf_valid` loads all limits, effective for eligibility from the next cycle.
  - A limit lowered below the current in-flight count blocks that context until it drains below the new limit.
  - A limit of 0 disables the context.
- `inflight` saturates at `2^CREDIT_WIDTH-1`; this is reachable only when limit equals the maximum.

## Timing
- Reset values:
  - `m_her_valid`=0; all `m_her_*` fields 0; `s_her_ready`=0; `feedback_ready`=0.
  - `inflight`=0; `rr_ptr`=0; all limits=`DEFAULT_CREDITS`; `stat_underflow`=0.
- `feedback_ready` goes to 1 on the first clock after `rst` deasserts.
- Latency: request accepted in cycle N → `m_her_valid` high in cycle N+1.
- Throughput is one HER per cycle while `m_her_ready` is held high.
- `m_her_*` holds stable while `m_her_valid && !m_her_ready`.
- `s_her_ready` depends combinationally on `s_her_valid`, `m_her_valid`, and `m_her_ready`. It is never asserted for a non-valid context.
- `stat_inflight` is registered and reflects updates one cycle after the grant or feedback.
- Asserting `rst` mid-transfer drops the registered HER immediately and clears all counters. Sources must re-present their requests.

## Structure
- Shared package `pspin_her_pkg`: `ctx_idx_t`, `credit_t`, and an HER field struct (addr, size, msgid, is_eom).
- One sub-module, `pspin_rr_arbiter`: parameterised width, request vector plus pointer in, one-hot grant plus index out, purely combinational.
- Counters, pointer, and output register live in the top module.

## Test plan
- Single context 0 with limit 2 and no feedback: sends 3 requests → 2 granted, the third stalls. One feedback with ctx 0 → third granted the next cycle; `stat_inflight[0]` reads 2.
- All 4 contexts continuously valid, `m_her_ready`=1, limits 16: grants run 0,1,2,3,0,… one per cycle, with `m_her_ctx` matching the sequence.
- Backpressure: `m_her_ready`=0 for 5 cycles → output fields stable, `s_her_ready`=0. Release → next grant resumes from `rr_ptr`.
- Simultaneous grant and feedback on ctx 1 with inflight=3 → inflight stays 3. Feedback for ctx 2 with inflight=0 → `stat_underflow`=1, counter stays 0.
- `conf_valid` with limit[3]=0 while inflight[3]=4 → context 3 is never granted. Four feedbacks bring inflight[3] to 0; the context stays blocked.
- Assert `rst` while `m_her_valid`=1 → `m_her_valid` is 0 in the same cycle. After release, limits read back as 16 and counters as 0.

Source files
------------

// File: rtl/pspin_her_pkg.sv
// ----------------------------------------------------------------------------
// pspin_her_pkg
// Shared definitions for the per-context HER scheduler:
//   - default configuration constants (used as parameter defaults by the top)
//   - ctx_idx_t / credit_t for the default configuration
//   - her_t: the HER payload fields carried from a source to the PsPIN port
//   - rr_next(): round-robin pointer advance with modulo wrap
// ----------------------------------------------------------------------------
package pspin_her_pkg;

    localparam int PKG_NUM_CTX         = 4;
    localparam int PKG_ADDR_W          = 32;
    localparam int PKG_MSGID_W         = 10;
    localparam int PKG_CREDIT_W        = 8;
    localparam int PKG_DEFAULT_CREDITS = 16;
    localparam int PKG_CTX_W           = $clog2(PKG_NUM_CTX);

    typedef logic [PKG_CTX_W-1:0]    ctx_idx_t;
    typedef logic [PKG_CREDIT_W-1:0] credit_t;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0]  addr;
        logic [PKG_ADDR_W-1:0]  size;
        logic [PKG_MSGID_W-1:0] msgid;
        logic                   is_eom;
    } her_t;

    // Index following idx in a ring of n entries.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pspin_rr_arbiter.sv
// ----------------------------------------------------------------------------
// pspin_rr_arbiter
// Purely combinational round-robin picker. Grants the first requesting index
// found scanning from i_ptr upward, wrapping past N-1 back to 0.
// Ports:
//   i_req        N   request vector
//   i_ptr        IW  scan start index
//   o_grant      N   one-hot grant (zero when nothing requests)
//   o_grant_idx  IW  binary index of the granted request
//   o_any        1   at least one request was granted
// ----------------------------------------------------------------------------
module pspin_rr_arbiter
    import pspin_her_pkg::*;
#(
    parameter int N  = PKG_NUM_CTX,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_any
);

    // Two passes realise the wrap: first indices at/above the pointer, then
    // the remaining low indices. The first hit wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!o_any && i_req[j] && (j >= int'(i_ptr))) begin
                o_any       = 1'b1;
                o_grant[j]  = 1'b1;
                o_grant_idx = IW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!o_any && i_req[j]) begin
                o_any       = 1'b1;
                o_grant[j]  = 1'b1;
                o_grant_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/pspin_her_sched.sv
// ----------------------------------------------------------------------------
// pspin_her_sched
// Round-robin HER scheduler between NUM_HANDLER_CTX per-context HER sources
// and the single PsPIN wrapper HER port, with per-context in-flight credits.
//
// Handshake: every stream uses valid/ready. A transfer happens on a rising
// clock edge where both valid and ready are high; a producer holds valid and
// payload stable until that edge, and ready never depends on the consumer's
// own registered state in a way that could loop back to valid.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   conf_credit_limit   per-context in-flight limits, latched on conf_valid
//   s_her_*             per-context request streams (ready is one-hot/zero)
//   m_her_*             registered HER output tagged with m_her_ctx
//   feedback_*          PsPIN completion; releases one credit of feedback_ctx
//   stat_inflight       registered per-context in-flight counts
//   stat_underflow      sticky: completion with nothing in flight / bad ctx
// ----------------------------------------------------------------------------
module pspin_her_sched
    import pspin_her_pkg::*;
#(
    parameter int NUM_HANDLER_CTX = PKG_NUM_CTX,
    parameter int AXI_ADDR_WIDTH  = PKG_ADDR_W,
    parameter int MSG_ID_WIDTH    = PKG_MSGID_W,
    parameter int CREDIT_WIDTH    = PKG_CREDIT_W,
    parameter int DEFAULT_CREDITS = PKG_DEFAULT_CREDITS,
    parameter int CTX_WIDTH       = $clog2(NUM_HANDLER_CTX)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_HANDLER_CTX*CREDIT_WIDTH-1:0]   conf_credit_limit,
    input  logic                                      conf_valid,
    input  logic [NUM_HANDLER_CTX-1:0]                s_her_valid,
    output logic [NUM_HANDLER_CTX-1:0]                s_her_ready,
    input  logic [NUM_HANDLER_CTX*AXI_ADDR_WIDTH-1:0] s_her_addr,
    input  logic [NUM_HANDLER_CTX*AXI_ADDR_WIDTH-1:0] s_her_size,
    input  logic [NUM_HANDLER_CTX*MSG_ID_WIDTH-1:0]   s_her_msgid,
    input  logic [NUM_HANDLER_CTX-1:0]                s_her_is_eom,
    output logic                                      m_her_valid,
    input  logic                                      m_her_ready,
    output logic [AXI_ADDR_WIDTH-1:0]                 m_her_addr,
    output logic [AXI_ADDR_WIDTH-1:0]                 m_her_size,
    output logic [MSG_ID_WIDTH-1:0]                   m_her_msgid,
    output logic                                      m_her_is_eom,
    output logic [CTX_WIDTH-1:0]                      m_her_ctx,
    input  logic                                      feedback_valid,
    output logic                                      feedback_ready,
    input  logic [CTX_WIDTH-1:0]                      feedback_ctx,
    output logic [NUM_HANDLER_CTX*CREDIT_WIDTH-1:0]   stat_inflight,
    output logic                                      stat_underflow
);

    typedef struct packed {
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [AXI_ADDR_WIDTH-1:0] size;
        logic [MSG_ID_WIDTH-1:0]   msgid;
        logic                      is_eom;
    } her_fields_t;

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = {CREDIT_WIDTH{1'b1}};

    // ------------------------------------------------------------------ state
    logic [CREDIT_WIDTH-1:0] r_limit    [NUM_HANDLER_CTX];
    logic [CREDIT_WIDTH-1:0] r_inflight [NUM_HANDLER_CTX];
    logic [CTX_WIDTH-1:0]    r_rr_ptr;
    logic                    r_m_valid;
    her_fields_t             r_m_her;
    logic [CTX_WIDTH-1:0]    r_m_ctx;
    logic                    r_underflow;
    // Set on the first clock out of reset; also gates grants so nothing is
    // accepted while reset is (or has just been) asserted.
    logic                    r_active;

    // ------------------------------------------------------------- datapath
    logic                       w_load;
    logic [NUM_HANDLER_CTX-1:0] w_req;
    logic [NUM_HANDLER_CTX-1:0] w_grant;
    logic [CTX_WIDTH-1:0]       w_grant_idx;
    logic                       w_grant_any;
    her_fields_t                w_sel;
    logic                       w_fb_fire;
    logic [NUM_HANDLER_CTX-1:0] w_fb_dec;
    logic                       w_fb_uflow;

    assign w_load = r_active && (!r_m_valid || m_her_ready);

    always_comb begin
        w_req = '0;
        for (int i = 0; i < NUM_HANDLER_CTX; i++) begin
            w_req[i] = w_load && s_her_valid[i] && (r_inflight[i] < r_limit[i]);
        end
    end

    pspin_rr_arbiter #(
        .N  (NUM_HANDLER_CTX),
        .IW (CTX_WIDTH)
    ) u_arb (
        .i_req       (w_req),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_grant_any)
    );

    assign s_her_ready = w_grant;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_HANDLER_CTX; i++) begin
            if (w_grant[i]) begin
                w_sel.addr   = s_her_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                w_sel.size   = s_her_size[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                w_sel.msgid  = s_her_msgid[i*MSG_ID_WIDTH +: MSG_ID_WIDTH];
                w_sel.is_eom = s_her_is_eom[i];
            end
        end
    end

    // Feedback decode: a completion only releases a credit that exists; a
    // completion for an idle or nonexistent context is flagged instead.
    assign w_fb_fire = feedback_valid && r_active;

    always_comb begin
        w_fb_dec   = '0;
        w_fb_uflow = 1'b0;
        if (w_fb_fire) begin
            if (int'(feedback_ctx) >= NUM_HANDLER_CTX) begin
                w_fb_uflow = 1'b1;
            end else begin
                for (int i = 0; i < NUM_HANDLER_CTX; i++) begin
                    if (CTX_WIDTH'(i) == feedback_ctx) begin
                        if (r_inflight[i] != '0) w_fb_dec[i] = 1'b1;
                        else                     w_fb_uflow  = 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------ credit counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_HANDLER_CTX; i++) begin
                r_inflight[i] <= '0;
                r_limit[i]    <= CREDIT_WIDTH'(DEFAULT_CREDITS);
            end
        end else begin
            for (int i = 0; i < NUM_HANDLER_CTX; i++) begin
                // Grant and release in the same cycle cancel out.
                if (w_grant[i] && !w_fb_dec[i] && (r_inflight[i] != CREDIT_MAX)) begin
                    r_inflight[i] <= r_inflight[i] + CREDIT_WIDTH'(1);
                end else if (!w_grant[i] && w_fb_dec[i]) begin
                    r_inflight[i] <= r_inflight[i] - CREDIT_WIDTH'(1);
                end
                if (conf_valid) begin
                    r_limit[i] <= conf_credit_limit[i*CREDIT_WIDTH +: CREDIT_WIDTH];
                end
            end
        end
    end

    // -------------------------------------------- output register / pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active    <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_her     <= '0;
            r_m_ctx     <= '0;
            r_rr_ptr    <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_active    <= 1'b1;
            r_underflow <= r_underflow | w_fb_uflow;
            if (w_load) begin
                if (w_grant_any) begin
                    r_m_valid <= 1'b1;
                    r_m_her   <= w_sel;
                    r_m_ctx   <= w_grant_idx;
                    r_rr_ptr  <= CTX_WIDTH'(rr_next(int'(w_grant_idx), NUM_HANDLER_CTX));
                end else begin
                    r_m_valid <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        stat_inflight = '0;
        for (int i = 0; i < NUM_HANDLER_CTX; i++) begin
            stat_inflight[i*CREDIT_WIDTH +: CREDIT_WIDTH] = r_inflight[i];
        end
    end

    assign m_her_valid    = r_m_valid;
    assign m_her_addr     = r_m_her.addr;
    assign m_her_size     = r_m_her.size;
    assign m_her_msgid    = r_m_her.msgid;
    assign m_her_is_eom   = r_m_her.is_eom;
    assign m_her_ctx      = r_m_ctx;
    assign feedback_ready = r_active;
    assign stat_underflow = r_underflow;

endmodule
